// File: rtl/longop_scoreboard.sv
// longop_scoreboard: issue/hazard controller for the iterative divider and the
// multi-cycle FPU. It tracks per-register busy bits for the integer and FP files,
// stalls ID on RAW/WAW/structural hazards, sequences unit start pulses and
// arbitrates the shared integer writeback port.
// Latency: stall, acks and writeback controls are combinational; busy bits and
// unit FSMs update at the CLK edge. A start pulse is issued one cycle after accept.
// Backpressure: stall holds IF/ID. A unit's done stays high until its ack; an
// integer result that loses arbitration is retried the next cycle.
// Ports:
//   CLK, rst_n                         clock, async active-low reset
//   iss_*                              ID instruction: op type, rd/rs indices, files
//   flush                              blocks acceptance of the ID instruction
//   div_done / fpu_done                unit result valid (held until ack)
//   stall                              hold IF/ID
//   div_start / fpu_start              one-cycle start pulses
//   div_wb_ack / fpu_wb_ack            result consumed
//   wb_int_en/_rd/_sel                 integer writeback (sel: 0 divider, 1 FPU)
//   wb_fp_en/_rd                       FP writeback
// Build option: define SB_RR_ARB_EN for round-robin integer writeback arbitration;
// otherwise the divider has fixed priority over the FPU.

module longop_scoreboard #(
  parameter int NREG = 32
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       iss_valid,
  input  logic       iss_idiv,
  input  logic       iss_fpu,
  input  logic [4:0] iss_rd,
  input  logic       iss_rd_int,
  input  logic       iss_rd_fp,
  input  logic [4:0] iss_rs1,
  input  logic [4:0] iss_rs2,
  input  logic       iss_rs1_en,
  input  logic       iss_rs2_en,
  input  logic       iss_rs1_fp,
  input  logic       iss_rs2_fp,
  input  logic       flush,
  input  logic       div_done,
  input  logic       fpu_done,
  output logic       stall,
  output logic       div_start,
  output logic       fpu_start,
  output logic       div_wb_ack,
  output logic       fpu_wb_ack,
  output logic       wb_int_en,
  output logic [4:0] wb_int_rd,
  output logic       wb_int_sel,
  output logic       wb_fp_en,
  output logic [4:0] wb_fp_rd
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      div_st_q, div_st_d;
  logic [1:0]      fpu_st_q, fpu_st_d;
  logic [4:0]      div_rd_q, div_rd_d;
  logic            div_int_q, div_int_d;
  logic [4:0]      fpu_rd_q, fpu_rd_d;
  logic            fpu_int_q, fpu_int_d;
  logic            fpu_fp_q, fpu_fp_d;
  logic [NREG-1:0] int_busy_q, int_busy_d;
  logic [NREG-1:0] fp_busy_q, fp_busy_d;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic rs1_busy, rs2_busy, rd_busy, struct_haz, live, accept;
  logic div_acc, fpu_acc;

  // x0 is never busy; the extra index check keeps that true even if a
  // stray set ever reached bit 0.
  assign rs1_busy = iss_rs1_en & (iss_rs1_fp ? fp_busy_q[iss_rs1]
                                             : (int_busy_q[iss_rs1] & (iss_rs1 != 5'd0)));
  assign rs2_busy = iss_rs2_en & (iss_rs2_fp ? fp_busy_q[iss_rs2]
                                             : (int_busy_q[iss_rs2] & (iss_rs2 != 5'd0)));
  assign rd_busy  = (iss_rd_int & int_busy_q[iss_rd] & (iss_rd != 5'd0)) |
                    (iss_rd_fp  & fp_busy_q[iss_rd]);

  // Structural hazard uses the registered state, so an ack in this cycle
  // still stalls a new op for the same unit until the FSM is back in IDLE.
  assign struct_haz = (iss_idiv & (div_st_q != ST_IDLE)) |
                      (iss_fpu  & (fpu_st_q != ST_IDLE));

  assign live    = iss_valid & ~flush;
  assign stall   = live & (rs1_busy | rs2_busy | rd_busy | struct_haz);
  assign accept  = live & ~stall;
  assign div_acc = accept & iss_idiv;
  assign fpu_acc = accept & iss_fpu;

  // ---------------------------------------------------------------------------
  // Writeback and arbitration
  // ---------------------------------------------------------------------------
  logic div_pend, fpu_pend;
  logic div_req_int, fpu_req_int, fpu_req_fp;
  logic grant_div, grant_fpu, prio_div;

  // done is only meaningful in RUN; it is ignored in IDLE and START.
  assign div_pend = (div_st_q == ST_RUN) & div_done;
  assign fpu_pend = (fpu_st_q == ST_RUN) & fpu_done;

  // An FPU op with an FP destination uses the FP port; otherwise an integer
  // destination competes for the shared integer port.
  assign div_req_int = div_pend & div_int_q;
  assign fpu_req_fp  = fpu_pend & fpu_fp_q;
  assign fpu_req_int = fpu_pend & ~fpu_fp_q & fpu_int_q;

`ifdef SB_RR_ARB_EN
  // Pointer: 0 = divider has priority, 1 = FPU has priority.
  logic prio_fpu_q, prio_fpu_d;

  // Each contended grant hands priority to the loser; since the winner is
  // always the prioritised unit, that is a toggle.
  always_comb begin
    prio_fpu_d = prio_fpu_q;
    if (div_req_int && fpu_req_int) begin
      prio_fpu_d = ~prio_fpu_q;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      prio_fpu_q <= 1'b0;
    end else begin
      prio_fpu_q <= prio_fpu_d;
    end
  end

  assign prio_div = ~prio_fpu_q;
`else
  assign prio_div = 1'b1;
`endif

  assign grant_div = div_req_int & (~fpu_req_int | prio_div);
  assign grant_fpu = fpu_req_int & ~grant_div;

  // Results with no architectural destination are consumed immediately.
  assign div_wb_ack = grant_div | (div_pend & ~div_int_q);
  assign fpu_wb_ack = fpu_req_fp | grant_fpu | (fpu_pend & ~fpu_fp_q & ~fpu_int_q);

  assign wb_int_en  = grant_div | grant_fpu;
  assign wb_int_sel = grant_fpu;
  assign wb_int_rd  = grant_fpu ? fpu_rd_q : (grant_div ? div_rd_q : 5'd0);
  assign wb_fp_en   = fpu_req_fp;
  assign wb_fp_rd   = fpu_req_fp ? fpu_rd_q : 5'd0;

  assign div_start  = (div_st_q == ST_START);
  assign fpu_start  = (fpu_st_q == ST_START);

  // ---------------------------------------------------------------------------
  // Unit FSMs and tags
  // ---------------------------------------------------------------------------
  always_comb begin
    div_st_d = div_st_q;
    case (div_st_q)
      ST_IDLE:  if (div_acc) div_st_d = ST_START;
      ST_START: div_st_d = ST_RUN;
      ST_RUN:   if (div_wb_ack) div_st_d = ST_IDLE;
      default:  div_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fpu_st_d = fpu_st_q;
    case (fpu_st_q)
      ST_IDLE:  if (fpu_acc) fpu_st_d = ST_START;
      ST_START: fpu_st_d = ST_RUN;
      ST_RUN:   if (fpu_wb_ack) fpu_st_d = ST_IDLE;
      default:  fpu_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_rd_d  = div_rd_q;
    div_int_d = div_int_q;
    fpu_rd_d  = fpu_rd_q;
    fpu_int_d = fpu_int_q;
    fpu_fp_d  = fpu_fp_q;
    if (div_acc) begin
      div_rd_d  = iss_rd;
      div_int_d = iss_rd_int;
    end
    if (fpu_acc) begin
      fpu_rd_d  = iss_rd;
      fpu_int_d = iss_rd_int;
      fpu_fp_d  = iss_rd_fp;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy bits: clear on ack, set on accept of a long op. A set and a clear can
  // never hit the same register in one cycle because the set would be a WAW stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    int_busy_d = int_busy_q;
    fp_busy_d  = fp_busy_q;
    if (div_wb_ack && div_int_q) begin
      int_busy_d[div_rd_q] = 1'b0;
    end
    if (fpu_wb_ack) begin
      if (fpu_fp_q) begin
        fp_busy_d[fpu_rd_q] = 1'b0;
      end else if (fpu_int_q) begin
        int_busy_d[fpu_rd_q] = 1'b0;
      end
    end
    if (div_acc && iss_rd_int && (iss_rd != 5'd0)) begin
      int_busy_d[iss_rd] = 1'b1;
    end
    if (fpu_acc) begin
      if (iss_rd_fp) begin
        fp_busy_d[iss_rd] = 1'b1;
      end else if (iss_rd_int && (iss_rd != 5'd0)) begin
        int_busy_d[iss_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_st_q   <= ST_IDLE;
      fpu_st_q   <= ST_IDLE;
      div_rd_q   <= 5'd0;
      div_int_q  <= 1'b0;
      fpu_rd_q   <= 5'd0;
      fpu_int_q  <= 1'b0;
      fpu_fp_q   <= 1'b0;
      int_busy_q <= '0;
      fp_busy_q  <= '0;
    end else begin
      div_st_q   <= div_st_d;
      fpu_st_q   <= fpu_st_d;
      div_rd_q   <= div_rd_d;
      div_int_q  <= div_int_d;
      fpu_rd_q   <= fpu_rd_d;
      fpu_int_q  <= fpu_int_d;
      fpu_fp_q   <= fpu_fp_d;
      int_busy_q <= int_busy_d;
      fp_busy_q  <= fp_busy_d;
    end
  end

endmodule

// File: tb/tb_longop_scoreboard.sv
// Testbench for longop_scoreboard: directed issue sequences with a writeback
// scoreboard. Expected integer/FP writebacks are queued when an op is accepted
// and compared when the DUT raises a writeback enable.

module tb_longop_scoreboard;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       iss_valid, iss_idiv, iss_fpu;
  logic [4:0] iss_rd, iss_rs1, iss_rs2;
  logic       iss_rd_int, iss_rd_fp;
  logic       iss_rs1_en, iss_rs2_en, iss_rs1_fp, iss_rs2_fp;
  logic       flush, div_done, fpu_done;
  logic       stall, div_start, fpu_start, div_wb_ack, fpu_wb_ack;
  logic       wb_int_en, wb_int_sel, wb_fp_en;
  logic [4:0] wb_int_rd, wb_fp_rd;

  always #5 CLK = ~CLK;

  longop_scoreboard dut (
    .CLK(CLK), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_idiv(iss_idiv), .iss_fpu(iss_fpu),
    .iss_rd(iss_rd), .iss_rd_int(iss_rd_int), .iss_rd_fp(iss_rd_fp),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
    .iss_rs1_fp(iss_rs1_fp), .iss_rs2_fp(iss_rs2_fp),
    .flush(flush), .div_done(div_done), .fpu_done(fpu_done),
    .stall(stall), .div_start(div_start), .fpu_start(fpu_start),
    .div_wb_ack(div_wb_ack), .fpu_wb_ack(fpu_wb_ack),
    .wb_int_en(wb_int_en), .wb_int_rd(wb_int_rd), .wb_int_sel(wb_int_sel),
    .wb_fp_en(wb_fp_en), .wb_fp_rd(wb_fp_rd)
  );

  typedef struct {
    logic [4:0] rd;
    logic       sel;
  } wb_t;

  wb_t        int_q[$];
  logic [4:0] fp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic       first_fpu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_int(input logic [4:0] rd, input logic sel);
    wb_t e;
    e.rd  = rd;
    e.sel = sel;
    int_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    iss_valid = 0; iss_idiv = 0; iss_fpu = 0;
    iss_rd = 0; iss_rd_int = 0; iss_rd_fp = 0;
    iss_rs1 = 0; iss_rs2 = 0; iss_rs1_en = 0; iss_rs2_en = 0;
    iss_rs1_fp = 0; iss_rs2_fp = 0; flush = 0;
  endtask

  task automatic issue(input logic idiv, input logic fpu, input logic [4:0] rd,
                       input logic rd_int, input logic rd_fp, input logic [4:0] rs1,
                       input logic rs1_en, input logic rs1_fp);
    iss_valid = 1; iss_idiv = idiv; iss_fpu = fpu;
    iss_rd = rd; iss_rd_int = rd_int; iss_rd_fp = rd_fp;
    iss_rs1 = rs1; iss_rs1_en = rs1_en; iss_rs1_fp = rs1_fp;
    iss_rs2 = 0; iss_rs2_en = 0; iss_rs2_fp = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_div_start"}, div_start, 0);
    chk({tag, "_fpu_start"}, fpu_start, 0);
    chk({tag, "_div_ack"}, div_wb_ack, 0);
    chk({tag, "_fpu_ack"}, fpu_wb_ack, 0);
    chk({tag, "_wb_int_en"}, wb_int_en, 0);
    chk({tag, "_wb_int_rd"}, wb_int_rd, 0);
    chk({tag, "_wb_int_sel"}, wb_int_sel, 0);
    chk({tag, "_wb_fp_en"}, wb_fp_en, 0);
    chk({tag, "_wb_fp_rd"}, wb_fp_rd, 0);
  endtask

  // Writeback scoreboard: every writeback must match the oldest expectation.
  always @(negedge CLK) begin : sb_mon
    wb_t e;
    logic [4:0] f;
    if (rst_n) begin
      if (wb_int_en) begin
        if (int_q.size() == 0) begin
          total++; bad++;
          $error("FAIL wb_int_unexpected observed_rd=%0d expected=none", wb_int_rd);
        end else begin
          e = int_q.pop_front();
          chk("sb_wb_int_rd", wb_int_rd, e.rd);
          chk("sb_wb_int_sel", wb_int_sel, e.sel);
        end
      end
      if (wb_fp_en) begin
        if (fp_q.size() == 0) begin
          total++; bad++;
          $error("FAIL wb_fp_unexpected observed_rd=%0d expected=none", wb_fp_rd);
        end else begin
          f = fp_q.pop_front();
          chk("sb_wb_fp_rd", wb_fp_rd, f);
        end
      end
    end
  end

  // Decode never marks an instruction as both div and FP long op.
  always @(negedge CLK) begin
    if (iss_valid && iss_idiv && iss_fpu) begin
      bad++;
      $error("FAIL illegal_issue observed=idiv&fpu expected=exclusive");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; div_done = 0; fpu_done = 0;
    idle_in();
    tick(); tick();
    chk_zero("reset");
    rst_n = 1;
    tick();

    // A: divide x5, dependent add stalls until the cycle after writeback
    issue(1, 0, 5, 1, 0, 0, 0, 0); #1;
    chk("A_accept", stall, 0);
    chk("A_no_early_start", div_start, 0);
    exp_int(5, 0);
    tick();
    issue(0, 0, 6, 1, 0, 5, 1, 0); #1;
    chk("A_div_start", div_start, 1);
    chk("A_raw_stall", stall, 1);
    tick(); #1;
    chk("A_start_pulse_end", div_start, 0);
    chk("A_raw_stall_run", stall, 1);
    tick();
    div_done = 1; #1;
    chk("A_ack", div_wb_ack, 1);
    chk("A_wb_en", wb_int_en, 1);
    chk("A_stall_wb_cycle", stall, 1);
    tick();
    div_done = 0; #1;
    chk("A_raw_release", stall, 0);
    chk("A_no_ack_after", div_wb_ack, 0);
    tick();
    idle_in();

    // B: divide to x0; x0 reads never stall; done in START is ignored
    issue(1, 0, 0, 1, 0, 0, 0, 0); #1;
    chk("B_accept", stall, 0);
    exp_int(0, 0);
    tick();
    issue(0, 0, 1, 1, 0, 0, 1, 0);
    div_done = 1; #1;
    chk("B_x0_no_stall", stall, 0);
    chk("B_done_in_start_ack", div_wb_ack, 0);
    chk("B_done_in_start_wb", wb_int_en, 0);
    tick();
    idle_in(); #1;
    chk("B_ack_run", div_wb_ack, 1);
    chk("B_wb_en", wb_int_en, 1);
    chk("B_wb_rd0", wb_int_rd, 0);
    tick();
    div_done = 0;

    // C: divider and FPU (fcvt.w.s -> x7) finish together
    issue(1, 0, 9, 1, 0, 0, 0, 0); #1;
    chk("C_div_accept", stall, 0);
    exp_int(9, 0);
    tick();
    issue(0, 1, 7, 1, 0, 1, 1, 1); #1;
    chk("C_fpu_accept", stall, 0);
    exp_int(7, 1);
    tick();
    idle_in(); #1;
    chk("C_fpu_start", fpu_start, 1);
    tick();
    div_done = 1; fpu_done = 1; #1;
    chk("C1_div_ack", div_wb_ack, 1);
    chk("C1_fpu_wait", fpu_wb_ack, 0);
    chk("C1_sel", wb_int_sel, 0);
    tick();
    div_done = 0; #1;
    chk("C2_fpu_ack", fpu_wb_ack, 1);
    chk("C2_sel", wb_int_sel, 1);
    chk("C2_rd", wb_int_rd, 7);
    tick();
    fpu_done = 0;

    // C': second contention; round-robin hands it to the FPU
`ifdef SB_RR_ARB_EN
    first_fpu = 1'b1;
`else
    first_fpu = 1'b0;
`endif
    issue(1, 0, 10, 1, 0, 0, 0, 0); #1;
    chk("C3_div_accept", stall, 0);
    tick();
    issue(0, 1, 11, 1, 0, 1, 1, 1); #1;
    chk("C3_fpu_accept", stall, 0);
    if (first_fpu) begin
      exp_int(11, 1); exp_int(10, 0);
    end else begin
      exp_int(10, 0); exp_int(11, 1);
    end
    tick();
    idle_in();
    tick();
    div_done = 1; fpu_done = 1; #1;
    chk("C3_first_sel", wb_int_sel, first_fpu);
    chk("C3_first_div_ack", div_wb_ack, !first_fpu);
    chk("C3_first_fpu_ack", fpu_wb_ack, first_fpu);
    tick();
    if (first_fpu) fpu_done = 0; else div_done = 0;
    #1;
    chk("C4_second_sel", wb_int_sel, !first_fpu);
    tick();
    div_done = 0; fpu_done = 0;

    // D: second divide while the divider runs
    issue(1, 0, 12, 1, 0, 0, 0, 0); #1;
    chk("D_first_accept", stall, 0);
    exp_int(12, 0);
    tick();
    issue(1, 0, 13, 1, 0, 0, 0, 0); #1;
    chk("D_struct_stall", stall, 1);
    tick(); #1;
    chk("D_stall_run", stall, 1);
    chk("D_no_restart", div_start, 0);
    tick();
    div_done = 1; #1;
    chk("D_stall_ack_cycle", stall, 1);
    chk("D_ack", div_wb_ack, 1);
    tick();
    div_done = 0; #1;
    chk("D_accept_after_ack", stall, 0);
    chk("D_no_start_yet", div_start, 0);
    exp_int(13, 0);
    tick();
    idle_in(); #1;
    chk("D_second_start", div_start, 1);
    tick();
    div_done = 1; #1;
    chk("D_second_ack", div_wb_ack, 1);
    tick();
    div_done = 0;

    // E: flushed divide does nothing; in-flight FPU (f3) still writes back
    issue(0, 1, 3, 0, 1, 0, 0, 0); #1;
    chk("E_fpu_accept", stall, 0);
    fp_q.push_back(5'd3);
    tick();
    issue(0, 0, 4, 0, 1, 3, 1, 1); #1;
    chk("E_fp_raw_stall", stall, 1);
    tick();
    issue(1, 0, 14, 1, 0, 0, 0, 0);
    flush = 1; #1;
    chk("E_flush_no_stall", stall, 0);
    tick();
    issue(0, 0, 15, 1, 0, 14, 1, 0);
    fpu_done = 1; #1;
    chk("E_no_div_start", div_start, 0);
    chk("E_no_busy_x14", stall, 0);
    chk("E_fp_wb_en", wb_fp_en, 1);
    chk("E_fp_wb_rd", wb_fp_rd, 3);
    chk("E_fpu_ack", fpu_wb_ack, 1);
    chk("E_no_int_wb", wb_int_en, 0);
    tick();
    fpu_done = 0;
    idle_in();
    tick();

    // F: reset in the middle of a divide
    issue(1, 0, 20, 1, 0, 0, 0, 0); #1;
    chk("F_accept", stall, 0);
    tick();
    idle_in();
    tick();
    issue(1, 0, 21, 1, 0, 20, 1, 0); #1;
    chk("F_pre_reset_stall", stall, 1);
    div_done = 1;
    rst_n = 0; #1;
    chk_zero("F_reset");
    idle_in();
    div_done = 0;
    tick();
    rst_n = 1;
    issue(1, 0, 21, 1, 0, 20, 1, 0); #1;
    chk("F_post_reset_accept", stall, 0);
    exp_int(21, 0);
    tick();
    idle_in(); #1;
    chk("F_start", div_start, 1);
    tick();
    div_done = 1; #1;
    chk("F_ack", div_wb_ack, 1);
    chk("F_wb_rd", wb_int_rd, 21);
    tick();
    div_done = 0;
    tick();

    chk("sb_int_drained", int_q.size(), 0);
    chk("sb_fp_drained", fp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
